// File: rtl/adxl345_sequencer.sv
// -----------------------------------------------------------------------------
// adxl345_sequencer
//
// Autonomous ADXL345 controller. After start it reads DEVID (expects 0xE5),
// writes BW_RATE, DATA_FORMAT, INT_ENABLE and POWER_CTL, then waits for the
// device interrupt. On irq it reads INT_SOURCE and, when DATA_READY (bit 7) is
// set, burst-reads DATAX0..DATAZ1 and presents one signed X/Y/Z sample.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start               pulse; (re)starts initialisation from IDLE or FAULT
//   irq                 asynchronous level interrupt from the device
//   m_cmd_*             command to the byte-level I2C master (valid/ready)
//   m_rd_valid/m_rd_data  received bytes from the master
//   m_done/m_nack       transaction completion and NACK status
//   sample_*            assembled sample, sample_valid pulses once per update
//   busy, init_done     status
//   error, error_code   sticky fault: 1 bad DEVID, 2 NACK/short read, 3 timeout
// -----------------------------------------------------------------------------
module adxl345_sequencer #(
  parameter logic [6:0]  DEVICE_ADDR     = 7'h53,
  parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
  parameter logic [7:0]  DATA_FORMAT_VAL = 8'h08,
  parameter logic [7:0]  INT_ENABLE_VAL  = 8'h80,
  parameter logic [7:0]  POWER_CTL_VAL   = 8'h08,
  parameter int unsigned TIMEOUT_CYCLES  = 200000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               irq,
  output logic               m_cmd_valid,
  input  logic               m_cmd_ready,
  output logic [6:0]         m_cmd_dev,
  output logic               m_cmd_rnw,
  output logic [7:0]         m_cmd_reg,
  output logic [2:0]         m_cmd_len,
  output logic [7:0]         m_cmd_wdata,
  input  logic               m_rd_valid,
  input  logic [7:0]         m_rd_data,
  input  logic               m_done,
  input  logic               m_nack,
  output logic               sample_valid,
  output logic signed [15:0] sample_x,
  output logic signed [15:0] sample_y,
  output logic signed [15:0] sample_z,
  output logic [7:0]         sample_int_source,
  output logic               busy,
  output logic               init_done,
  output logic               error,
  output logic [1:0]         error_code
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ID_REQ    = 4'd1;
  localparam logic [3:0] S_ID_WAIT   = 4'd2;
  localparam logic [3:0] S_CFG_REQ   = 4'd3;
  localparam logic [3:0] S_CFG_WAIT  = 4'd4;
  localparam logic [3:0] S_ARMED     = 4'd5;
  localparam logic [3:0] S_INT_REQ   = 4'd6;
  localparam logic [3:0] S_INT_WAIT  = 4'd7;
  localparam logic [3:0] S_DATA_REQ  = 4'd8;
  localparam logic [3:0] S_DATA_WAIT = 4'd9;
  localparam logic [3:0] S_EMIT      = 4'd10;
  localparam logic [3:0] S_FAULT     = 4'd11;

  localparam logic [7:0] REG_DEVID      = 8'h00;
  localparam logic [7:0] REG_INT_SOURCE = 8'h30;
  localparam logic [7:0] REG_DATAX0     = 8'h32;
  localparam logic [7:0] DEVID_VALUE    = 8'hE5;

  localparam logic [1:0] CODE_DEVID   = 2'd1;
  localparam logic [1:0] CODE_XFER    = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Configuration table: {register, value} in the order it is written.
  function automatic logic [15:0] cfg_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_entry = {8'h2C, BW_RATE_VAL};
      2'd1:    cfg_entry = {8'h31, DATA_FORMAT_VAL};
      2'd2:    cfg_entry = {8'h2E, INT_ENABLE_VAL};
      default: cfg_entry = {8'h2D, POWER_CTL_VAL};
    endcase
  endfunction

  logic [3:0]      r_state;
  logic            r_irq_meta;
  logic            r_irq_sync;
  logic [1:0]      r_cfg_idx;
  logic [2:0]      r_byte_cnt;
  logic [TO_W-1:0] r_timeout_cnt;
  logic [7:0]      r_buf [0:5];
  logic [7:0]      r_int_source;

  logic [3:0]  w_state_next;
  logic [1:0]  w_cfg_idx_next;
  logic [1:0]  w_fault_code;
  logic        w_in_wait;
  logic        w_rd_accept;
  logic [2:0]  w_byte_total;
  logic        w_xfer_fail;
  logic        w_timeout;
  logic [7:0]  w_byte0;
  logic        w_enter_req;
  logic        w_enter_wait;
  logic        w_start_ok;
  logic        w_busy_next;
  logic [15:0] w_cfg_next;

  assign w_in_wait = (r_state == S_ID_WAIT) || (r_state == S_CFG_WAIT) ||
                     (r_state == S_INT_WAIT) || (r_state == S_DATA_WAIT);

  // Bytes past the requested length are dropped; a byte arriving together
  // with m_done still counts toward the total.
  assign w_rd_accept  = w_in_wait && m_rd_valid && (r_byte_cnt < m_cmd_len);
  assign w_byte_total = r_byte_cnt + 3'(w_rd_accept);
  assign w_xfer_fail  = m_nack || (m_cmd_rnw && (w_byte_total < m_cmd_len));
  assign w_timeout    = (r_timeout_cnt == TO_LAST);

  // Single-byte reads complete on m_done, possibly with the byte in that cycle.
  assign w_byte0 = (w_rd_accept && (r_byte_cnt == 3'd0)) ? m_rd_data : r_buf[0];

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_FAULT));

  // NOTE: every signal assigned in this always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    w_cfg_idx_next = r_cfg_idx;
    w_fault_code   = 2'd0;
    case (r_state)
      S_IDLE, S_FAULT: if (start) w_state_next = S_ID_REQ;
      S_ID_REQ:        if (m_cmd_ready) w_state_next = S_ID_WAIT;
      S_ID_WAIT: begin
        if (m_done) begin
          if (w_byte0 == DEVID_VALUE) begin
            w_state_next   = S_CFG_REQ;
            w_cfg_idx_next = 2'd0;
          end else begin
            w_state_next = S_FAULT;
            w_fault_code = CODE_DEVID;
          end
        end
      end
      S_CFG_REQ:  if (m_cmd_ready) w_state_next = S_CFG_WAIT;
      S_CFG_WAIT: begin
        if (m_done) begin
          if (r_cfg_idx == 2'd3) begin
            w_state_next = S_ARMED;
          end else begin
            w_state_next   = S_CFG_REQ;
            w_cfg_idx_next = r_cfg_idx + 2'd1;
          end
        end
      end
      S_ARMED:    if (r_irq_sync) w_state_next = S_INT_REQ;
      S_INT_REQ:  if (m_cmd_ready) w_state_next = S_INT_WAIT;
      S_INT_WAIT: if (m_done) w_state_next = w_byte0[7] ? S_DATA_REQ : S_ARMED;
      S_DATA_REQ: if (m_cmd_ready) w_state_next = S_DATA_WAIT;
      S_DATA_WAIT: if (m_done) w_state_next = S_EMIT;
      S_EMIT:     w_state_next = S_ARMED;
      default:    w_state_next = S_IDLE;
    endcase

    // Transfer failures override whatever the per-state logic chose.
    if (w_in_wait) begin
      if (m_done && w_xfer_fail) begin
        w_state_next   = S_FAULT;
        w_fault_code   = CODE_XFER;
        w_cfg_idx_next = r_cfg_idx;
      end else if (!m_done && w_timeout) begin
        w_state_next = S_FAULT;
        w_fault_code = CODE_TIMEOUT;
      end
    end
  end

  assign w_enter_req = (w_state_next != r_state) &&
                       ((w_state_next == S_ID_REQ) || (w_state_next == S_CFG_REQ) ||
                        (w_state_next == S_INT_REQ) || (w_state_next == S_DATA_REQ));
  assign w_enter_wait = (w_state_next != r_state) &&
                        ((w_state_next == S_ID_WAIT) || (w_state_next == S_CFG_WAIT) ||
                         (w_state_next == S_INT_WAIT) || (w_state_next == S_DATA_WAIT));
  assign w_busy_next = !((w_state_next == S_IDLE) || (w_state_next == S_ARMED) ||
                         (w_state_next == S_FAULT));
  assign w_cfg_next  = cfg_entry(w_cfg_idx_next);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_irq_meta        <= 1'b0;
      r_irq_sync        <= 1'b0;
      r_cfg_idx         <= 2'd0;
      r_byte_cnt        <= 3'd0;
      r_timeout_cnt     <= '0;
      r_int_source      <= 8'd0;
      // NOTE: the six-byte burst buffer is plain flops, not a RAM, so it is
      // reset along with everything else and never exposes stale bytes.
      for (int i = 0; i < 6; i++) r_buf[i] <= 8'd0;
      m_cmd_valid       <= 1'b0;
      m_cmd_dev         <= 7'd0;
      m_cmd_rnw         <= 1'b0;
      m_cmd_reg         <= 8'd0;
      m_cmd_len         <= 3'd0;
      m_cmd_wdata       <= 8'd0;
      sample_valid      <= 1'b0;
      sample_x          <= '0;
      sample_y          <= '0;
      sample_z          <= '0;
      sample_int_source <= 8'd0;
      busy              <= 1'b0;
      init_done         <= 1'b0;
      error             <= 1'b0;
      error_code        <= 2'd0;
    end else begin
      r_state      <= w_state_next;
      r_irq_meta   <= irq;
      r_irq_sync   <= r_irq_meta;
      r_cfg_idx    <= w_cfg_idx_next;
      busy         <= w_busy_next;
      sample_valid <= 1'b0;

      // Command issue: fields are loaded once on REQ entry and then held,
      // so they stay stable for as long as the master stalls.
      if (m_cmd_valid && m_cmd_ready) m_cmd_valid <= 1'b0;
      if (w_enter_req) begin
        m_cmd_valid <= 1'b1;
        m_cmd_dev   <= DEVICE_ADDR;
        case (w_state_next)
          S_ID_REQ: begin
            m_cmd_rnw   <= 1'b1;
            m_cmd_reg   <= REG_DEVID;
            m_cmd_len   <= 3'd1;
            m_cmd_wdata <= 8'd0;
          end
          S_CFG_REQ: begin
            m_cmd_rnw   <= 1'b0;
            m_cmd_reg   <= w_cfg_next[15:8];
            m_cmd_len   <= 3'd1;
            m_cmd_wdata <= w_cfg_next[7:0];
          end
          S_INT_REQ: begin
            m_cmd_rnw   <= 1'b1;
            m_cmd_reg   <= REG_INT_SOURCE;
            m_cmd_len   <= 3'd1;
            m_cmd_wdata <= 8'd0;
          end
          default: begin
            m_cmd_rnw   <= 1'b1;
            m_cmd_reg   <= REG_DATAX0;
            m_cmd_len   <= 3'd6;
            m_cmd_wdata <= 8'd0;
          end
        endcase
      end

      if (w_in_wait) begin
        r_timeout_cnt <= r_timeout_cnt + 1'b1;
        if (w_rd_accept) r_byte_cnt <= r_byte_cnt + 3'd1;
        for (int i = 0; i < 6; i++) begin
          if (w_rd_accept && (r_byte_cnt == 3'(i))) r_buf[i] <= m_rd_data;
        end
      end
      if (w_enter_wait) begin
        r_timeout_cnt <= '0;
        r_byte_cnt    <= 3'd0;
      end

      if ((r_state == S_INT_WAIT) && m_done && !w_xfer_fail) r_int_source <= w_byte0;

      if (r_state == S_EMIT) begin
        sample_x          <= {r_buf[1], r_buf[0]};
        sample_y          <= {r_buf[3], r_buf[2]};
        sample_z          <= {r_buf[5], r_buf[4]};
        sample_int_source <= r_int_source;
        sample_valid      <= 1'b1;
      end

      if (w_start_ok) begin
        error      <= 1'b0;
        error_code <= 2'd0;
        init_done  <= 1'b0;
      end
      if ((r_state == S_CFG_WAIT) && (w_state_next == S_ARMED)) init_done <= 1'b1;
      if ((w_state_next == S_FAULT) && (r_state != S_FAULT)) begin
        error      <= 1'b1;
        error_code <= w_fault_code;
      end
    end
  end

endmodule

// File: tb/tb_adxl345_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adxl345_sequencer
//
// Drives adxl345_sequencer through an imitation I2C master. A table of
// command records holds the expected command fields together with the
// master's response; each record is pushed to a scoreboard queue and popped
// when the DUT presents the command. Expected samples are queued when the
// data burst is driven and compared when sample_valid pulses.
// -----------------------------------------------------------------------------
module tb_adxl345_sequencer;

  localparam int TB_TO = 40;

  typedef struct packed {
    logic        rnw;
    logic [7:0]  rg;
    logic [2:0]  len;
    logic [7:0]  wdata;
    logic [3:0]  nb;        // bytes the master returns
    logic [55:0] resp;      // byte i in resp[8*i +: 8]
    logic        with_done; // last byte shares the m_done cycle
    logic        nack;
    logic [3:0]  stall;     // cycles m_cmd_ready is withheld (start pulsed)
    logic        no_done;   // master never finishes
  } cmd_vec_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [7:0]  src;
  } samp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic irq = 1'b0;
  logic m_cmd_valid;
  logic m_cmd_ready = 1'b0;
  logic [6:0] m_cmd_dev;
  logic m_cmd_rnw;
  logic [7:0] m_cmd_reg;
  logic [2:0] m_cmd_len;
  logic [7:0] m_cmd_wdata;
  logic m_rd_valid = 1'b0;
  logic [7:0] m_rd_data = 8'd0;
  logic m_done = 1'b0;
  logic m_nack = 1'b0;
  logic sample_valid;
  logic signed [15:0] sample_x, sample_y, sample_z;
  logic [7:0] sample_int_source;
  logic busy, init_done, error;
  logic [1:0] error_code;

  int n_checks = 0;
  int n_errors = 0;
  int n_samples = 0;

  cmd_vec_t tbl [18];
  cmd_vec_t q_exp_cmd [$];
  samp_t    q_exp_sample [$];

  always #5 clk = ~clk;

  adxl345_sequencer #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .reset(reset), .start(start), .irq(irq),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_dev(m_cmd_dev), .m_cmd_rnw(m_cmd_rnw), .m_cmd_reg(m_cmd_reg),
    .m_cmd_len(m_cmd_len), .m_cmd_wdata(m_cmd_wdata),
    .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data),
    .m_done(m_done), .m_nack(m_nack),
    .sample_valid(sample_valid), .sample_x(sample_x), .sample_y(sample_y),
    .sample_z(sample_z), .sample_int_source(sample_int_source),
    .busy(busy), .init_done(init_done), .error(error), .error_code(error_code)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic cmd_vec_t mk(input logic rnw, input logic [7:0] rg, input logic [2:0] len,
                                  input logic [7:0] wdata, input logic [3:0] nb,
                                  input logic [55:0] resp, input logic with_done,
                                  input logic nack, input logic [3:0] stall,
                                  input logic no_done);
    cmd_vec_t v;
    v.rnw = rnw; v.rg = rg; v.len = len; v.wdata = wdata; v.nb = nb;
    v.resp = resp; v.with_done = with_done; v.nack = nack; v.stall = stall;
    v.no_done = no_done;
    return v;
  endfunction

  // Sample scoreboard: compare on every sample_valid pulse.
  always @(negedge clk) begin
    samp_t e;
    if (!reset && sample_valid === 1'b1) begin
      n_samples++;
      if (q_exp_sample.size() == 0) begin
        check("sample_unexpected", sample_valid, 1'b0);
      end else begin
        e = q_exp_sample.pop_front();
        check("sample", {sample_x, sample_y, sample_z, sample_int_source}, e);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Imitation master: wait for the command, compare it with the scoreboard
  // head, accept it, then return bytes and completion.
  task automatic serve();
    cmd_vec_t e;
    int n;
    logic [26:0] snap;
    bit sent_done;
    e = q_exp_cmd.pop_front();
    n = 0;
    while (m_cmd_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (m_cmd_valid !== 1'b1) begin
      check("cmd_appear", m_cmd_valid, 1'b1);
      return;
    end
    snap = {m_cmd_dev, m_cmd_rnw, m_cmd_reg, m_cmd_len, m_cmd_wdata};
    check("cmd_fields", snap, {7'h53, e.rnw, e.rg, e.len, e.wdata});
    for (int s = 0; s < int'(e.stall); s++) begin
      if (s == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (e.stall != 4'd0) begin
      check("stall_fields", {m_cmd_dev, m_cmd_rnw, m_cmd_reg, m_cmd_len, m_cmd_wdata}, snap);
      check("stall_valid", m_cmd_valid, 1'b1);
      check("stall_busy", busy, 1'b1);
    end
    m_cmd_ready = 1'b1;
    irq = 1'b0;
    @(negedge clk);
    m_cmd_ready = 1'b0;
    check("cmd_drop", m_cmd_valid, 1'b0);
    if (e.no_done) return;
    @(negedge clk);
    sent_done = 1'b0;
    for (int i = 0; i < int'(e.nb); i++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = e.resp[8*i +: 8];
      if (i == int'(e.nb) - 1 && e.with_done) begin
        m_done = 1'b1;
        m_nack = e.nack;
        sent_done = 1'b1;
      end
      @(negedge clk);
      m_rd_valid = 1'b0;
      m_rd_data  = 8'd0;
      m_done = 1'b0;
      m_nack = 1'b0;
    end
    if (!sent_done) begin
      m_done = 1'b1;
      m_nack = e.nack;
      @(negedge clk);
      m_done = 1'b0;
      m_nack = 1'b0;
    end
  endtask

  task automatic run_range(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      q_exp_cmd.push_back(tbl[i]);
      serve();
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen = seen | m_cmd_valid;
    end
    check(name, seen, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1'b1, 8'h00, 3'd1, 8'h00, 4'd1, 56'hE5, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[1]  = mk(1'b0, 8'h2C, 3'd1, 8'h0A, 4'd0, 56'h0, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[2]  = mk(1'b0, 8'h31, 3'd1, 8'h08, 4'd0, 56'h0, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[3]  = mk(1'b0, 8'h2E, 3'd1, 8'h80, 4'd0, 56'h0, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[4]  = mk(1'b0, 8'h2D, 3'd1, 8'h08, 4'd0, 56'h0, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[5]  = mk(1'b1, 8'h30, 3'd1, 8'h00, 4'd1, 56'h80, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[6]  = mk(1'b1, 8'h32, 3'd6, 8'h00, 4'd6, 56'h00_FF_F0_00_10_FF_F0, 1'b1, 1'b0, 4'd0, 1'b0);
    tbl[7]  = mk(1'b1, 8'h30, 3'd1, 8'h00, 4'd1, 56'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[8]  = mk(1'b1, 8'h30, 3'd1, 8'h00, 4'd1, 56'h83, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[9]  = mk(1'b1, 8'h32, 3'd6, 8'h00, 4'd7, 56'hAA_80_00_7F_FF_00_01, 1'b1, 1'b0, 4'd0, 1'b0);
    tbl[10] = mk(1'b1, 8'h30, 3'd1, 8'h00, 4'd1, 56'h80, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[11] = mk(1'b1, 8'h32, 3'd6, 8'h00, 4'd5, 56'h00_00_05_04_03_02_01, 1'b1, 1'b0, 4'd0, 1'b0);
    tbl[12] = mk(1'b1, 8'h00, 3'd1, 8'h00, 4'd1, 56'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    tbl[13] = tbl[0];
    tbl[14] = tbl[1];
    tbl[15] = tbl[2];
    tbl[16] = mk(1'b0, 8'h2E, 3'd1, 8'h80, 4'd0, 56'h0, 1'b0, 1'b1, 4'd0, 1'b0);
    tbl[17] = mk(1'b1, 8'h30, 3'd1, 8'h00, 4'd0, 56'h0, 1'b0, 1'b0, 4'd6, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_error", {error, error_code}, 3'd0);
    check("rst_cmd", {m_cmd_valid, m_cmd_dev, m_cmd_rnw, m_cmd_reg, m_cmd_len, m_cmd_wdata}, 28'd0);
    check("rst_sample", {sample_valid, sample_x, sample_y, sample_z, sample_int_source}, 57'd0);

    // Initialisation: DEVID then four writes in order
    pulse_start();
    check("start_busy", busy, 1'b1);
    run_range(0, 4);
    check("init_done", init_done, 1'b1);
    check("init_busy", busy, 1'b0);
    check("init_error", error, 1'b0);

    // irq -> INT_SOURCE 0x80 -> data burst -> one sample
    irq = 1'b1;
    @(negedge clk);
    check("irq_lat_k", m_cmd_valid, 1'b0);
    @(negedge clk);
    check("irq_lat_k1", m_cmd_valid, 1'b0);
    @(negedge clk);
    check("irq_lat_k2", m_cmd_valid, 1'b1);
    run_range(5, 5);
    q_exp_sample.push_back('{x: 16'hFFF0, y: 16'h0010, z: 16'hFFF0, src: 8'h80});
    run_range(6, 6);
    check("emit_lat0", sample_valid, 1'b0);
    @(negedge clk);
    check("emit_lat1", sample_valid, 1'b1);
    @(negedge clk);
    check("emit_pulse_end", sample_valid, 1'b0);
    check("emit_busy", busy, 1'b0);

    // INT_SOURCE without DATA_READY: no data read, no sample
    irq = 1'b1;
    run_range(7, 7);
    expect_quiet("no_data_cmd", 10);
    check("no_data_busy", busy, 1'b0);
    check("no_data_samples", n_samples, 1);

    // Second sample; a seventh byte beyond the length is ignored
    irq = 1'b1;
    run_range(8, 8);
    q_exp_sample.push_back('{x: 16'h0001, y: 16'h7FFF, z: 16'h8000, src: 8'h83});
    run_range(9, 9);
    repeat (3) @(negedge clk);
    check("hold_x", sample_x, 16'h0001);

    // Short data burst -> FAULT code 2, init_done kept
    irq = 1'b1;
    run_range(10, 11);
    check("short_error", {error, error_code}, 3'b110);
    check("short_init_done", init_done, 1'b1);
    check("short_busy", busy, 1'b0);

    // Bad DEVID -> FAULT code 1, no writes issued
    pulse_start();
    check("restart_clear", {error, error_code, init_done}, 4'd0);
    run_range(12, 12);
    check("devid_error", {error, error_code}, 3'b101);
    expect_quiet("devid_no_write", 10);

    // NACK on third write -> code 2, POWER_CTL never issued
    pulse_start();
    run_range(13, 16);
    check("nack_error", {error, error_code}, 3'b110);
    check("nack_init_done", init_done, 1'b0);
    expect_quiet("nack_no_powerctl", 10);

    // Stalled INT_REQ with start pulsed, then timeout in INT_WAIT
    pulse_start();
    run_range(0, 4);
    check("reinit_done", init_done, 1'b1);
    irq = 1'b1;
    run_range(17, 17);
    repeat (TB_TO - 1) @(negedge clk);
    check("timeout_before", error, 1'b0);
    @(negedge clk);
    check("timeout_error", {error, error_code}, 3'b111);
    check("timeout_busy", busy, 1'b0);

    // Reset while a transaction is in flight
    pulse_start();
    begin
      int n;
      n = 0;
      while (m_cmd_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    m_cmd_ready = 1'b1;
    @(negedge clk);
    m_cmd_ready = 1'b0;
    check("midrst_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_state", {busy, m_cmd_valid, error, init_done}, 4'd0);
    m_rd_valid = 1'b1;
    m_rd_data  = 8'hE5;
    m_done = 1'b1;
    @(negedge clk);
    m_rd_valid = 1'b0;
    m_done = 1'b0;
    expect_quiet("midrst_stray_done", 6);
    check("midrst_busy_after", busy, 1'b0);

    check("cmd_queue_empty", q_exp_cmd.size(), 0);
    check("sample_queue_empty", q_exp_sample.size(), 0);
    check("sample_count", n_samples, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
